data_mem_resp: RTL and testbench

Multi-cycle data-memory responder for the pipelined processor's memory stage. It accepts one read or write request at a time and holds the pipeline with `stall` for a fixed latency. It then completes the access with a one-cycle `done` pulse, with read data valid in that cycle. Malformed requests raise a sticky `err`, which the top level ORs into the processor `err`.

---
 rtl/mem_resp_pkg.sv | 24 ++
 rtl/mem_array.sv | 29 ++
 rtl/data_mem_resp.sv | 130 +++++++++++++
 tb/tb_data_mem_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Request payload held from acceptance until the access edge
  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read, contents survive reset.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: one request in flight, fixed latency,
// stall while busy, one-cycle done pulse, sticky error on malformed requests.
module data_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam int unsigned CNT_LOAD  = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam bit          ONE_CYCLE = (LATENCY == 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  req_t                    cap;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic                    cap_load;
  logic                    err_set;
  logic                    rd_valid;

  logic                    acc_en;
  logic                    acc_wr;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [DATA_W-1:0]       acc_wdata;
  logic [DATA_W-1:0]       mem_q;

  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic                    req_ok;
  logic                    req_bad;

  // Byte address to word index; upper bits wrap and are deliberately dropped
  assign addr_idx = addr[DEPTH_LOG2:1];
  wire unused_addr = ^{addr[DATA_W-1:DEPTH_LOG2+1]};

  assign req_ok  = (rd ^ wr) & ~addr[0];
  assign req_bad = (rd | wr) & ~req_ok;

  // Next-state, counter and access control
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cap_load  = 1'b0;
    err_set   = 1'b0;
    acc_en    = 1'b0;
    acc_wr    = (cap.op == OP_WR);
    acc_idx   = cap_idx;
    acc_wdata = cap.wdata;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_n = IDLE;
        if (req_ok) begin
          cap_load = 1'b1;
          if (ONE_CYCLE) begin
            // Single-cycle latency: the access uses the live request directly
            state_n   = DONE;
            acc_en    = 1'b1;
            acc_wr    = wr;
            acc_idx   = addr_idx;
            acc_wdata = wdata;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_W'(CNT_LOAD);
          end
        end else if (req_bad) begin
          err_set = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = DONE;
          acc_en  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap      <= '0;
      cap_idx  <= '0;
      stall    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap_load) begin
        cap.op    <= wr ? OP_WR : OP_RD;
        cap.wdata <= wdata;
        cap_idx   <= addr_idx;
      end
      stall <= (state_n == BUSY);
      done  <= (state_n == DONE);
      if (err_set) err <= 1'b1;
      if (acc_en && !acc_wr) rd_valid <= 1'b1;
    end
  end

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .en   (acc_en),
    .we   (acc_wr),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .q    (mem_q)
  );

  // Storage read register has no reset, so read data is gated until a read completes
  assign rdata = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (LATENCY=4 main instance, LATENCY=1 variant).
module tb_data_mem_resp;

  localparam int unsigned LAT = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, wdata, rdata;
  logic        done, stall, err;

  logic        rd1, wr1;
  logic [15:0] addr1, wdata1, rdata1;
  logic        done1, stall1, err1;

  int          ncmp = 0;
  int          nbad = 0;
  exp_t        sb[$];
  exp_t        cur;
  logic        stall1_seen = 1'b0;
  vec_t        tbl[10];

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .stall(stall), .err(err)
  );

  data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .rd(rd1), .wr(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .done(done1), .stall(stall1), .err(err1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expectation; reads compare rdata
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        ncmp++;
        nbad++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        cur = sb.pop_front();
        if (cur.is_rd) chk({cur.tag, "_rdata"}, rdata, cur.data);
      end
    end
    if (stall1) stall1_seen = 1'b1;
  end

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle
  task automatic run_req(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp, input string tag);
    rd = r; wr = w; addr = a; wdata = d;
    sb.push_back('{is_rd: r, data: exp, tag: tag});
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    for (int k = 1; k < int'(LAT); k++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 16'(stall), 16'd1);
      chk({tag, "_done_early"}, 16'(done), 16'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_stall_at_done"}, 16'(stall), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 16'h0202, 16'h1234, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 16'h03FE, 16'hA5A5, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 16'hA5A5};
    tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    tbl[8] = '{1'b0, 1'b1, 16'h0010, 16'hCAFE, 16'h0000};
    tbl[9] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hCAFE};

    rst = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    rst = 1'b1;
    @(negedge clk);

    // LATENCY=1: write then back-to-back read in the DONE cycle
    wr1 = 1'b1; addr1 = 16'h0044; wdata1 = 16'h9999;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b1;
    @(negedge clk);
    chk("l1_wr_done", 16'(done1), 16'd1);
    chk("l1_wr_stall", 16'(stall1), 16'd0);
    @(posedge clk); #1;
    rd1 = 1'b0;
    @(negedge clk);
    chk("l1_rd_done", 16'(done1), 16'd1);
    chk("l1_rd_rdata", rdata1, 16'h9999);
    @(negedge clk);
    chk("l1_idle_done", 16'(done1), 16'd0);
    chk("l1_err", 16'(err1), 16'd0);

    // Table: back-to-back accesses, each presented in the previous DONE cycle
    for (int i = 0; i < 10; i++)
      run_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
              $sformatf("vec%0d", i));
    @(negedge clk);
    chk("tbl_idle_done", 16'(done), 16'd0);
    chk("tbl_idle_stall", 16'(stall), 16'd0);

    // Inputs changing during BUSY must be ignored
    run_req(1'b0, 1'b1, 16'h0040, 16'h7777, 16'h0, "pre_wr40");
    wr = 1'b1; addr = 16'h0030; wdata = 16'h1111;
    sb.push_back('{is_rd: 1'b0, data: 16'h0, tag: "busy_wr30"});
    @(posedge clk); #1;
    for (int k = 1; k < int'(LAT); k++) begin
      rd = (k == 2); wr = 1'b1;
      addr = (k == 1) ? 16'h0040 : 16'h0031;
      wdata = 16'($urandom);
      @(negedge clk);
      chk("busy_stall", 16'(stall), 16'd1);
      @(posedge clk); #1;
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("busy_done", 16'(done), 16'd1);
    chk("busy_err", 16'(err), 16'd0);
    run_req(1'b1, 1'b0, 16'h0030, 16'h0, 16'h1111, "rd30");
    run_req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h7777, "rd40");

    // Reset in the middle of a write: outputs clear at once, storage keeps old data
    run_req(1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0, "wr20_old");
    @(negedge clk);
    wr = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("abort_stall_c1", 16'(stall), 16'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_stall", 16'(stall), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_err", 16'(err), 16'd0);
    chk("abort_rdata", rdata, 16'h0000);
    chk("abort_rdata1", rdata1, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      @(negedge clk);
      chk("post_abort_done", 16'(done), 16'd0);
    end
    run_req(1'b1, 1'b0, 16'h0020, 16'h0, 16'h5555, "rd20_after_abort");
    @(negedge clk);

    // Unaligned read then unaligned write: sticky err, no access
    chk("pre_unal_err", 16'(err), 16'd0);
    rd = 1'b1; addr = 16'h0003;
    #1;
    chk("unal_err_not_comb", 16'(err), 16'd0);
    @(posedge clk); #1;
    rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("unal_err", 16'(err), 16'd1);
      chk("unal_stall", 16'(stall), 16'd0);
      chk("unal_done", 16'(done), 16'd0);
    end
    wr = 1'b1; addr = 16'h0011; wdata = 16'hDEAD;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("unal_wr_stall", 16'(stall), 16'd0);
    chk("unal_wr_done", 16'(done), 16'd0);
    run_req(1'b1, 1'b0, 16'h0010, 16'h0, 16'hCAFE, "rd10_untouched");
    chk("err_held", 16'(err), 16'd1);

    // Reset clears err; both strobes together is rejected
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", 16'(err), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 16'h0010; wdata = 16'h0BAD;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("both_err", 16'(err), 16'd1);
    chk("both_stall", 16'(stall), 16'd0);
    chk("both_done", 16'(done), 16'd0);
    @(negedge clk);
    run_req(1'b1, 1'b0, 16'h0010, 16'h0, 16'hCAFE, "rd10_after_both");
    @(negedge clk); @(negedge clk);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    chk("l1_stall_never", 16'(stall1_seen), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
